// File: rtl/dsram_ctrl_pkg.sv
// Shared types and defaults for the 16-bit asynchronous SRAM data-memory controller.
// The access FSM walks IDLE -> LO/HI halfword phases -> DONE.
package dsram_ctrl_pkg;

   typedef enum logic [1:0] {
      DsrIdle = 2'd0,
      DsrLo   = 2'd1,
      DsrHi   = 2'd2,
      DsrDone = 2'd3
   } dsr_state_e;

   localparam int unsigned DefaultWaitCycles = 1;

   // Byte enables of the halfword addressed by the given phase ({ub, lb} order).
   function automatic logic [1:0] half_bwe(input logic [3:0] bwe, input logic hi);
      return hi ? bwe[3:2] : bwe[1:0];
   endfunction

endpackage

// File: rtl/dsram_ctrl_sram_phase_cnt.sv
// Per-phase cycle counter: SETUP (1) + PULSE (WAIT_CYCLES) + HOLD (1), cleared on phase entry.
// Flags decode the current cycle; pulse_next tells the strobe flops what the next cycle is.
module sram_phase_cnt #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic is_setup,
   output logic is_pulse,
   output logic is_last,
   output logic pulse_next
);

   localparam int unsigned CntW = $clog2(WAIT_CYCLES + 2);
   localparam logic [CntW-1:0] LastCnt  = CntW'(WAIT_CYCLES + 1);
   localparam logic [CntW-1:0] PulseEnd = CntW'(WAIT_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Saturates on the HOLD cycle so an idle controller never wraps into a fake pulse.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (!is_last) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_setup   = (cnt_q == '0);
   assign is_last    = (cnt_q == LastCnt);
   assign is_pulse   = !is_setup && !is_last;
   assign pulse_next = !clear && (cnt_q < PulseEnd);

endmodule

// File: rtl/dsram_ctrl.sv
// MEM-stage data-memory responder driving an asynchronous 16-bit SRAM in two halfword phases.
// Returns the raw 32-bit load word; lane alignment happens upstream.
module dsram_ctrl
   import dsram_ctrl_pkg::*;
#(
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        MEM_Addr_in,
   input  logic               MEM_memop_in,
   input  logic               MEM_memwr_in,
   input  logic [3:0]         MEM_bwe_in,
   input  logic [31:0]        MEM_STData_in,
   output logic [31:0]        MEM_LDData_out,
   output logic               mem_stall_out,
   output logic [SRAM_AW-1:0] sram_addr_out,
   input  logic [15:0]        sram_dq_in,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   dsr_state_e state_q, state_d;

   logic [SRAM_AW-2:0] addr_q;
   logic               wr_q;
   logic [3:0]         bwe_q;
   logic [31:0]        data_q;
   logic [15:0]        lo_buf_q;
   logic [31:0]        ld_q;

   logic [SRAM_AW-2:0] req_addr;
   logic               req_wr;
   logic [3:0]         req_bwe;
   logic [31:0]        req_data;

   logic is_setup, is_pulse, is_last, pulse_next;
   logic cnt_clear, phase_next, hi_next;

   logic               ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, dq_oe_q;
   logic               ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d;
   logic [SRAM_AW-1:0] addr_out_q, addr_out_d;
   logic [15:0]        dq_out_q, dq_out_d;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{MEM_Addr_in[31:SRAM_AW+1], MEM_Addr_in[1:0]};

   sram_phase_cnt #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_phase_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (cnt_clear),
      .is_setup   (is_setup),
      .is_pulse   (is_pulse),
      .is_last    (is_last),
      .pulse_next (pulse_next)
   );

   // In IDLE the request is still on the inputs; afterwards the latched copy is authoritative.
   always_comb begin
      if (state_q == DsrIdle) begin
         req_addr = MEM_Addr_in[SRAM_AW:2];
         req_wr   = MEM_memwr_in;
         req_bwe  = MEM_bwe_in;
         req_data = MEM_STData_in;
      end else begin
         req_addr = addr_q;
         req_wr   = wr_q;
         req_bwe  = bwe_q;
         req_data = data_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DsrIdle: begin
            if (MEM_memop_in) begin
               if (MEM_memwr_in && (MEM_bwe_in[1:0] == 2'b00)) begin
                  state_d = (MEM_bwe_in[3:2] == 2'b00) ? DsrDone : DsrHi;
               end else begin
                  state_d = DsrLo;
               end
            end
         end
         DsrLo: begin
            if (is_last) begin
               state_d = (wr_q && (bwe_q[3:2] == 2'b00)) ? DsrDone : DsrHi;
            end
         end
         DsrHi: begin
            if (is_last) begin
               state_d = DsrDone;
            end
         end
         DsrDone: state_d = DsrIdle;
         default: state_d = DsrIdle;
      endcase
   end

   assign phase_next = (state_d == DsrLo) || (state_d == DsrHi);
   assign hi_next    = (state_d == DsrHi);
   assign cnt_clear  = phase_next && (state_d != state_q);

   // Strobes are computed for the coming cycle so every SRAM pin leaves a flop.
   always_comb begin
      ce_n_d     = !phase_next;
      oe_n_d     = !(phase_next && !req_wr);
      we_n_d     = !(phase_next && req_wr && pulse_next);
      dq_oe_d    = phase_next && req_wr;
      addr_out_d = addr_out_q;
      dq_out_d   = dq_out_q;
      {ub_n_d, lb_n_d} = 2'b11;
      if (phase_next) begin
         addr_out_d = {req_addr, hi_next};
         {ub_n_d, lb_n_d} = req_wr ? ~half_bwe(req_bwe, hi_next) : 2'b00;
         if (req_wr) begin
            dq_out_d = hi_next ? req_data[31:16] : req_data[15:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= DsrIdle;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         bwe_q      <= 4'b0000;
         data_q     <= '0;
         lo_buf_q   <= '0;
         ld_q       <= '0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         ub_n_q     <= 1'b1;
         lb_n_q     <= 1'b1;
         dq_oe_q    <= 1'b0;
         addr_out_q <= '0;
         dq_out_q   <= '0;
      end else begin
         state_q    <= state_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         ub_n_q     <= ub_n_d;
         lb_n_q     <= lb_n_d;
         dq_oe_q    <= dq_oe_d;
         addr_out_q <= addr_out_d;
         dq_out_q   <= dq_out_d;
         if ((state_q == DsrIdle) && MEM_memop_in) begin
            addr_q <= req_addr;
            wr_q   <= req_wr;
            bwe_q  <= req_bwe;
            data_q <= req_data;
         end
         // The full word updates only at the end of HI so the previous load stays visible.
         if ((state_q == DsrLo) && is_last && !wr_q) begin
            lo_buf_q <= sram_dq_in;
         end
         if ((state_q == DsrHi) && is_last && !wr_q) begin
            ld_q <= {sram_dq_in, lo_buf_q};
         end
      end
   end

   always_comb begin
      mem_stall_out = ((state_q == DsrIdle) && MEM_memop_in) ||
                      (state_q == DsrLo) || (state_q == DsrHi);
   end

   assign MEM_LDData_out = ld_q;
   assign sram_addr_out  = addr_out_q;
   assign sram_dq_out    = dq_out_q;
   assign sram_dq_oe     = dq_oe_q;
   assign sram_ce_n      = ce_n_q;
   assign sram_oe_n      = oe_n_q;
   assign sram_we_n      = we_n_q;
   assign sram_ub_n      = ub_n_q;
   assign sram_lb_n      = lb_n_q;

   // The write strobe must line up with the counter's PULSE window, never SETUP.
   a_we_window: assert property (@(posedge clk) disable iff (!rst_n)
      ((state_q == DsrLo) || (state_q == DsrHi)) |-> (sram_we_n == !(wr_q && is_pulse)));
   a_setup_quiet: assert property (@(posedge clk) disable iff (!rst_n)
      ((state_q != DsrIdle) && (state_q != DsrDone) && is_setup) |-> sram_we_n);

endmodule

// File: tb/tb_dsram_ctrl.sv
// Scoreboard bench for dsram_ctrl: a behavioural SRAM plus a word-level reference memory;
// the driver queues expected results, a monitor checks each completed access.
module tb_dsram_ctrl;

   localparam int unsigned AW = 18;
   localparam int unsigned W  = 1;
   localparam int unsigned NWORDS = 1 << (AW - 1);

   logic          clk, rst_n;
   logic [31:0]   addr, st_data, ld_data;
   logic          memop, memwr, stall;
   logic [3:0]    bwe;
   logic [AW-1:0] sram_addr;
   logic [15:0]   dq_in, dq_out;
   logic          dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

   dsram_ctrl #(
      .SRAM_AW     (AW),
      .WAIT_CYCLES (W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .MEM_Addr_in    (addr),
      .MEM_memop_in   (memop),
      .MEM_memwr_in   (memwr),
      .MEM_bwe_in     (bwe),
      .MEM_STData_in  (st_data),
      .MEM_LDData_out (ld_data),
      .mem_stall_out  (stall),
      .sram_addr_out  (sram_addr),
      .sram_dq_in     (dq_in),
      .sram_dq_out    (dq_out),
      .sram_dq_oe     (dq_oe),
      .sram_ce_n      (ce_n),
      .sram_oe_n      (oe_n),
      .sram_we_n      (we_n),
      .sram_ub_n      (ub_n),
      .sram_lb_n      (lb_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural asynchronous SRAM (halfword array) and word-level reference memory.
   logic [15:0] sram [0:(1<<AW)-1];
   logic [31:0] ref_mem [0:NWORDS-1];

   assign dq_in = (!ce_n && !oe_n) ?
                  (sram[sram_addr] & {(ub_n ? 8'h00 : 8'hff), (lb_n ? 8'h00 : 8'hff)}) : 16'h0000;

   initial forever begin
      @(posedge clk);
      if (!ce_n && !we_n) begin
         if (!lb_n) sram[sram_addr][7:0]  = dq_oe ? dq_out[7:0]  : 8'h00;
         if (!ub_n) sram[sram_addr][15:8] = dq_oe ? dq_out[15:8] : 8'h00;
      end
   end

   typedef struct {
      logic [31:0] ld;
      int          stall;
      int          ce;
      int          we;
      int          oe;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] last_ld  = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   endtask

   // Monitor: count strobe activity per access, compare when the DUT releases the stall.
   int c_stall = 0, c_ce = 0, c_we = 0, c_oe = 0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         c_stall = 0; c_ce = 0; c_we = 0; c_oe = 0;
      end else begin
         if (stall) c_stall++;
         if (!ce_n) c_ce++;
         if (!we_n) c_we++;
         if (!oe_n) c_oe++;
         if (!memop) check("idle_ce_n", {31'b0, ce_n}, 32'd1);
         if (memop && !stall) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_done: got a completion, expected none at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("ld_data", ld_data, e.ld);
               check("stall_cycles", c_stall, e.stall);
               check("ce_cycles", c_ce, e.ce);
               check("we_cycles", c_we, e.we);
               check("oe_cycles", c_oe, e.oe);
            end
            c_stall = 0; c_ce = 0; c_we = 0; c_oe = 0;
         end
      end
   end

   // Driver: compute the expected outcome from the access rules, issue, wait for release.
   task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
      exp_t           e;
      logic [AW-2:0]  widx;
      logic [31:0]    prev_ld;
      int             nph;
      bit             done;
      widx    = a[AW:2];
      prev_ld = last_ld;
      if (wr) begin
         nph = int'(be[1:0] != 2'b00) + int'(be[3:2] != 2'b00);
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[widx][8*b +: 8] = d[8*b +: 8];
         end
         e.ld = last_ld; e.oe = 0; e.we = nph * W;
      end else begin
         nph = 2;
         e.ld = ref_mem[widx]; e.oe = 2 * (W + 2); e.we = 0;
         last_ld = e.ld;
      end
      e.ce    = nph * (W + 2);
      e.stall = 1 + nph * (W + 2);
      @(posedge clk);
      #1;
      memop = 1'b1; memwr = wr; addr = a; bwe = be; st_data = d;
      exp_q.push_back(e);
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            break;
         end
         check("ld_held", ld_data, prev_ld);
      end
      if (!done) begin
         n_checks++;
         n_fails++;
         $display("FAIL timeout: stall still 1 after 100 cycles, expected release");
         finish_test();
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      memop = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   initial begin
      logic [31:0] w, a, old_w, new_w;
      bit          hit;
      rst_n = 1'b0; memop = 1'b0; memwr = 1'b0; addr = '0; bwe = '0; st_data = '0;
      for (int i = 0; i < int'(NWORDS); i++) begin
         w = $urandom;
         ref_mem[i] = w;
         sram[2*i] = w[15:0];
         sram[2*i+1] = w[31:16];
      end
      repeat (3) @(negedge clk);
      check("rst_ld", ld_data, 32'h0);
      check("rst_strobes", {26'b0, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}, 32'b111110);
      check("rst_addr", {14'b0, sram_addr}, 32'h0);
      check("rst_dq_out", {16'b0, dq_out}, 32'h0);
      check("rst_stall", {31'b0, stall}, 32'h0);
      rst_n = 1'b1;
      idle(2);

      // Directed: read, full write, byte write, empty write, back-to-back reads.
      sram[18'h80] = 16'h5678; sram[18'h81] = 16'h1234; ref_mem[17'h40] = 32'h12345678;
      issue(1'b0, 32'h0000_0100, 4'b0000, 32'h0);
      idle(1);
      issue(1'b1, 32'h0000_0204, 4'b1111, 32'hAABBCCDD);
      idle(1);
      check("wr_hw102", {16'b0, sram[18'h102]}, 32'hCCDD);
      check("wr_hw103", {16'b0, sram[18'h103]}, 32'hAABB);
      issue(1'b1, 32'h0000_0204, 4'b0100, 32'h00EE0000);
      idle(1);
      check("sb_hw103", {16'b0, sram[18'h103]}, 32'hAAEE);
      check("sb_hw102", {16'b0, sram[18'h102]}, 32'hCCDD);
      issue(1'b1, 32'h0000_0208, 4'b0000, 32'hFFFFFFFF);
      issue(1'b0, 32'h0000_0100, 4'b0000, 32'h0);
      issue(1'b0, 32'h0000_0204, 4'b0000, 32'h0);
      idle(2);

      // Reset during the HI write pulse: LO already landed, HI must not.
      old_w = ref_mem[17'h82];
      new_w = 32'h13572468;
      @(posedge clk);
      #1;
      memop = 1'b1; memwr = 1'b1; addr = 32'h0000_0208; bwe = 4'b1111; st_data = new_w;
      hit = 1'b0;
      for (int i = 0, n = 0; i < 40; i++) begin
         @(negedge clk);
         if (!we_n) n++;
         if (n == 2) begin
            hit = 1'b1;
            break;
         end
      end
      check("rst_pulse_reached", {31'b0, hit}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_we_ce", {30'b0, we_n, ce_n}, 32'b11);
      check("midrst_dq_oe", {31'b0, dq_oe}, 32'h0);
      check("midrst_ld", ld_data, 32'h0);
      memop = 1'b0;
      check("midrst_lo_hw", {16'b0, sram[18'h104]}, {16'b0, new_w[15:0]});
      check("midrst_hi_hw", {16'b0, sram[18'h105]}, {16'b0, old_w[31:16]});
      ref_mem[17'h82] = {old_w[31:16], new_w[15:0]};
      last_ld = 32'h0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Random traffic over a small word pool, upper address bits randomised to test aliasing.
      for (int t = 0; t < 300; t++) begin
         a = $urandom;
         a[AW:2] = 17'h40 + 17'($urandom_range(0, 15));
         issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
      end
      idle(3);
      check("queue_drained", exp_q.size(), 32'd0);

      for (int i = 'h40; i < 'h50; i++) begin
         check("final_mem", {sram[2*i+1], sram[2*i]}, ref_mem[i]);
      end
      for (int i = 'h80; i < 'h83; i++) begin
         check("final_mem", {sram[2*i+1], sram[2*i]}, ref_mem[i]);
      end
      finish_test();
   end

endmodule
